// File: rtl/calculate_matrix_udiv_16ns_8ns_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : calculate_matrix_udiv_16ns_8ns_16_seq
// Description : Sequential unsigned restoring divider (din0 / din1). It
//               produces one quotient bit per enabled cycle and uses the
//               ap_start/ap_ready/ap_idle/ap_done block handshake.
//               Optional macro CALCULATE_MATRIX_UDIV_DIVZERO_FLAG_EN adds a
//               div_by_zero output that is registered at accept.
// Revision    : 1.0 - initial release
// ============================================================================
module calculate_matrix_udiv_16ns_8ns_16_seq #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      ap_ce,
  input  logic                      ap_start,
  output logic                      ap_ready,
  output logic                      ap_idle,
  output logic                      ap_done,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic [DIVIDEND_WIDTH-1:0] quot,
`ifdef CALCULATE_MATRIX_UDIV_DIVZERO_FLAG_EN
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      div_by_zero
`else
  output logic [DIVISOR_WIDTH-1:0]  rem
`endif
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CNT_W-1:0]          r_count;
  // Dividend register doubles as the quotient accumulator: dividend bits
  // leave at the MSB while quotient bits enter at the LSB.
  logic [DIVIDEND_WIDTH-1:0] r_dividend;
  logic [DIVISOR_WIDTH-1:0]  r_divisor;
  // Stored partial remainder. After each restoring step it is either below
  // the divisor or (divide by zero) just the low dividend bits, so it always
  // fits in DIVISOR_WIDTH bits; the extra bit exists only in w_shift.
  logic [DIVISOR_WIDTH-1:0]  r_prem;
  logic [DIVIDEND_WIDTH-1:0] r_quot;
  logic [DIVISOR_WIDTH-1:0]  r_rem;

  logic [DIVISOR_WIDTH:0]    w_shift;
  logic                      w_borrow;
  logic                      w_qbit;
  logic [DIVISOR_WIDTH-1:0]  w_diff;
  logic [DIVISOR_WIDTH-1:0]  w_prem_next;

  assign ap_idle  = (r_state == S_IDLE);
  assign ap_done  = (r_state == S_DONE);
  assign ap_ready = ap_idle & ap_start & ap_ce;
  assign quot     = r_quot;
  assign rem      = r_rem;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // The difference is only needed when there is no borrow, in which case it
  // is below the divisor and the low DIVISOR_WIDTH bits are exact.
  assign w_shift     = {r_prem, r_dividend[DIVIDEND_WIDTH-1]};
  assign w_borrow    = (w_shift < {1'b0, r_divisor});
  assign w_diff      = w_shift[DIVISOR_WIDTH-1:0] - r_divisor;
  assign w_qbit      = ~w_borrow;
  assign w_prem_next = w_borrow ? w_shift[DIVISOR_WIDTH-1:0] : w_diff;

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a low clock enable holds the current state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (ap_start && ap_ce)                 w_state_next = S_BUSY;
      S_BUSY:  if (ap_ce && r_count == CNT_W'(1))     w_state_next = S_DONE;
      S_DONE:  if (ap_ce)                             w_state_next = S_IDLE;
      default:                                        w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate while busy, publish results.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_count    <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_prem     <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
    end else if (ap_ce) begin
      if (ap_ready) begin
        r_dividend <= din0;
        r_divisor  <= din1;
        r_prem     <= '0;
        r_count    <= CNT_W'(DIVIDEND_WIDTH);
      end else if (r_state == S_BUSY) begin
        r_dividend <= {r_dividend[DIVIDEND_WIDTH-2:0], w_qbit};
        r_prem     <= w_prem_next;
        r_count    <= r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) begin
          r_quot <= {r_dividend[DIVIDEND_WIDTH-2:0], w_qbit};
          r_rem  <= w_prem_next;
        end
      end
    end
  end

`ifdef CALCULATE_MATRIX_UDIV_DIVZERO_FLAG_EN
  // Divide-by-zero flag, captured with the operands and held until next accept.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)        div_by_zero <= 1'b0;
    else if (ap_ready) div_by_zero <= (din1 == '0);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_calculate_matrix_udiv_16ns_8ns_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_calculate_matrix_udiv_16ns_8ns_16_seq
// Description : Self-checking bench for the sequential unsigned divider.
//               Directed corners plus randomized operands against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calculate_matrix_udiv_16ns_8ns_16_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_ce = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [15:0] din0 = '0;
  logic [7:0]  din1 = '0;
  logic [15:0] quot;
  logic [7:0]  rem;
`ifdef CALCULATE_MATRIX_UDIV_DIVZERO_FLAG_EN
  logic        div_by_zero;
`endif

  int checks = 0;
  int failures = 0;

  calculate_matrix_udiv_16ns_8ns_16_seq #(
    .DIVIDEND_WIDTH(16),
    .DIVISOR_WIDTH (8)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ap_ce      (ap_ce),
    .ap_start   (ap_start),
    .ap_ready   (ap_ready),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .din0       (din0),
    .din1       (din1),
    .quot       (quot),
`ifdef CALCULATE_MATRIX_UDIV_DIVZERO_FLAG_EN
    .rem        (rem),
    .div_by_zero(div_by_zero)
`else
    .rem        (rem)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, with the defined divide-by-zero result.
  function automatic logic [23:0] ref_div(input logic [15:0] a, input logic [7:0] b);
    int unsigned q;
    int unsigned r;
    if (b == 8'd0) begin
      q = 32'hFFFF;
      r = a % 256;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q[15:0], r[7:0]};
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Issue one division from idle; optional 5-cycle ce stall starting after
  // BUSY edge stall_at. Checks handshake, latency, result and hold.
  task automatic do_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input int stall_at);
    logic [23:0] exp;
    int lat;
    int exp_lat;
    exp = ref_div(a, b);
    exp_lat = (stall_at > 0) ? 21 : 16;
    din0 = a;
    din1 = b;
    ap_start = 1'b1;
    #1;
    chk({tag, "_ready"}, ap_ready, 1);
    tick();
    ap_start = 1'b0;
    din0 = 16'($urandom);
    din1 = 8'($urandom);
    chk({tag, "_busy_idle"}, ap_idle, 0);
    lat = 0;
    while (!ap_done && lat < 100) begin
      tick();
      lat++;
      if (stall_at > 0 && lat == stall_at) ap_ce = 1'b0;
      if (stall_at > 0 && lat == stall_at + 5) ap_ce = 1'b1;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_quot"}, quot, exp[23:8]);
    chk({tag, "_rem"}, rem, exp[7:0]);
    tick();
    chk({tag, "_done_pulse"}, ap_done, 0);
    chk({tag, "_idle_after"}, ap_idle, 1);
    chk({tag, "_quot_hold"}, quot, exp[23:8]);
    chk({tag, "_rem_hold"}, rem, exp[7:0]);
  endtask

  initial begin
    int acc[$];
    int n;
    logic [15:0] ra;
    logic [7:0]  rb;

    // Reset state
    #12;
    ap_rst = 1'b0;
    tick();
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_ready", ap_ready, 0);

    // Basic and corners
    do_div("basic", 16'd1000, 8'd7, 0);
    do_div("max", 16'd65535, 8'd255, 0);
    do_div("div1", 16'h1234, 8'd1, 0);
    do_div("small", 16'd7, 8'd200, 0);
    do_div("zero_num", 16'd0, 8'd9, 0);
    do_div("divzero", 16'd5, 8'd0, 0);
`ifdef CALCULATE_MATRIX_UDIV_DIVZERO_FLAG_EN
    chk("dbz_flag_set", div_by_zero, 1);
`endif
    do_div("after_dz", 16'd10, 8'd3, 0);
`ifdef CALCULATE_MATRIX_UDIV_DIVZERO_FLAG_EN
    chk("dbz_flag_clr", div_by_zero, 0);
`endif

    // Clock-enable stall mid-busy
    do_div("ce_stall", 16'd40000, 8'd37, 5);

    // Continuous ap_start: accepts must be 18 cycles apart
    din0 = 16'd1000;
    din1 = 8'd7;
    ap_start = 1'b1;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (ap_ready) acc.push_back(i);
      tick();
    end
    ap_start = 1'b0;
    chk("cont_accepts", (acc.size() >= 3) ? 1 : 0, 1);
    if (acc.size() >= 3) begin
      chk("cont_gap1", acc[1] - acc[0], 18);
      chk("cont_gap2", acc[2] - acc[1], 18);
    end
    n = 0;
    while (!ap_idle && n < 100) begin
      tick();
      n++;
    end
    chk("cont_drain", ap_idle, 1);
    chk("cont_quot", quot, 142);

    // Asynchronous abort at busy cycle 8
    din0 = 16'd5000;
    din1 = 8'd3;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #3;
    ap_rst = 1'b1;
    #1;
    chk("abort_quot", quot, 0);
    chk("abort_rem", rem, 0);
    chk("abort_idle", ap_idle, 1);
    chk("abort_done", ap_done, 0);
    #1;
    ap_rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ap_done) n++;
    end
    chk("abort_no_done", n, 0);
    do_div("post_abort", 16'd100, 8'd10, 0);

    // Randomized operands
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      do_div("rand", ra, rb, (i % 10 == 3) ? int'($urandom_range(1, 9)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calculate_matrix_udiv_16ns_8ns_16_seq.md
Name: calculate_matrix_udiv_16ns_8ns_16_seq

Overview:
- Sequential unsigned restoring divider: dividend din0 / divisor din1 -> quotient, remainder.
- Inverse operator to the matrix datapath multiplier; used for normalising/scaling matrix results (e.g. averaging accumulated products).
- Multi-cycle, one quotient bit per cycle, controlled by the ap_start/ap_done block-level handshake.

Parameters:
- DIVIDEND_WIDTH, 16, width of din0 and quot.
- DIVISOR_WIDTH, 8, width of din1 and rem.

Ports:
- ap_clk  input  1  clock, rising edge.
- ap_rst  input  1  reset, asynchronous, active-high.
- ap_ce  input  1  clock enable; 0 freezes all state.
- ap_start  input  1  request to divide din0/din1.
- ap_ready  output  1  operands consumed this cycle.
- ap_idle  output  1  block idle, can accept.
- ap_done  output  1  one-cycle pulse, results valid.
- din0  input  DIVIDEND_WIDTH  dividend, unsigned.
- din1  input  DIVISOR_WIDTH  divisor, unsigned.
- quot  output  DIVIDEND_WIDTH  quotient.
- rem  output  DIVISOR_WIDTH  remainder.

Behaviour:
- Reset (async, any time, including mid-division): state IDLE, count=0, quot=0, rem=0, ap_done=0, ap_idle=1. In-flight operation discarded, no ap_done.
- States: IDLE, BUSY, DONE.
- ap_ready = ap_idle & ap_start & ap_ce (combinational). The accept edge is a rising edge with ap_ready=1.
- IDLE -> BUSY on accept edge: latch din0 and din1; partial remainder (DIVISOR_WIDTH+1 bits) = 0; count = DIVIDEND_WIDTH.
- BUSY, each edge with ap_ce=1: shift next dividend bit (MSB first) into the partial remainder. Trial subtract divisor; if no borrow, keep the difference and set the quotient bit to 1, else restore and set it to 0. Decrement count.
- BUSY -> DONE on the edge that computes the last bit (count 1 -> 0). quot/rem registers update at that edge.
- Latency: ap_done is high in the cycle following the DIVIDEND_WIDTH-th edge after the accept edge (16 cycles by default).
- DONE: ap_done=1 for exactly one enabled cycle; next enabled edge -> IDLE.
- ap_start is ignored in BUSY and DONE. ap_idle=1 only in IDLE. Minimum issue interval is DIVIDEND_WIDTH+2 cycles.
- quot/rem hold their values from DONE until the next completion or reset. The din0/din1 latched copy makes later input changes irrelevant.
- ap_ce=0: no state, count, datapath or output register changes. ap_done stays at its current level and ap_ready=0.
- Divide by zero (din1=0): no special path; the algorithm runs its normal latency. Result is defined as quot = all ones, rem = din0[DIVISOR_WIDTH-1:0].
- Invariant for din1!=0: din0 == quot*din1 + rem and rem < din1.

Optional Feature:
- Macro: CALCULATE_MATRIX_UDIV_DIVZERO_FLAG_EN.
- Defined: adds output port div_by_zero (1 bit). It is registered at the accept edge as (din1==0), held until the next accept, and cleared by reset. Quotient/remainder behaviour is unchanged.
- Undefined: port absent; no extra logic.

Test Plan:
- Reset then idle: ap_rst pulse -> ap_idle=1, ap_done=0, quot=0, rem=0; ap_ready=0 while ap_start=0.
- Basic: din0=1000, din1=7, ap_start one cycle, ce=1 -> ap_done pulse exactly 16 cycles after accept; quot=142, rem=6; values held afterwards.
- Corners: 65535/255 -> 257 r 0. 0x1234/1 -> 0x1234 r 0. 7/200 -> 0 r 7. 0/9 -> 0 r 0.
- Divide by zero: 5/0 -> quot=0xFFFF, rem=5. With CALCULATE_MATRIX_UDIV_DIVZERO_FLAG_EN, div_by_zero=1 after accept; a following 10/3 run clears it, giving 3 r 1.
- Control: hold ap_start high continuously -> accepts spaced 18 cycles apart. Change din0/din1 during BUSY -> result unaffected. Drop ap_ce for 5 cycles mid-BUSY -> ap_done delayed by exactly 5 cycles, same result.
- Abort: assert ap_rst asynchronously (between clock edges) at BUSY cycle 8 -> outputs zero immediately, no ap_done. A new 100/10 run -> 10 r 0.
